// File: rtl/texel_block_unpacker_pkg.sv
// Shared types and constants for the 4x4 texel block unpacker and its format decoder.
package texel_unpack_pkg;

    typedef enum logic [1:0] {
        FMT_RGB565   = 2'd0,
        FMT_ARGB4444 = 2'd1,
        FMT_L8       = 2'd2,
        FMT_RSVD     = 2'd3
    } fmt_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

    localparam int RGBA_W           = 18;
    localparam int BLOCK_W          = 256;
    localparam int TEXELS_PER_BLOCK = 16;
    localparam int TEXEL_W          = 16;
    localparam int L8_W             = 8;

    // Output texel layout is {R5, G6, B5, A2}, R in the MSBs.
    function automatic logic [RGBA_W-1:0] pack_rgba(
        input logic [4:0] r5,
        input logic [5:0] g6,
        input logic [4:0] b5,
        input logic [1:0] a2
    );
        return {r5, g6, b5, a2};
    endfunction

endpackage

// File: rtl/texel_block_unpacker_fmt_decode.sv
// Combinational single-texel decoder: RGB565 / ARGB4444 / L8 raw value to RGBA5652.
// For L8 the parent places the luminance byte in raw[7:0].
module texel_fmt_decode
    import texel_unpack_pkg::*;
(
    input  logic [TEXEL_W-1:0] raw,
    input  fmt_e               fmt,
    output logic [RGBA_W-1:0]  rgba
);

    // Widen by replicating the top bits so full scale maps to full scale.
    function automatic logic [4:0] expand4to5(input logic [3:0] n);
        return {n, n[3]};
    endfunction

    function automatic logic [5:0] expand4to6(input logic [3:0] n);
        return {n, n[3:2]};
    endfunction

    always_comb begin
        rgba = pack_rgba(raw[15:11], raw[10:5], raw[4:0], 2'b11);
        case (fmt)
            FMT_ARGB4444: rgba = pack_rgba(expand4to5(raw[11:8]),
                                           expand4to6(raw[7:4]),
                                           expand4to5(raw[3:0]),
                                           raw[15:14]);
            FMT_L8:       rgba = pack_rgba(raw[7:3], raw[7:2], raw[7:3], 2'b11);
            // Reserved falls back to RGB565; the parent flags the error.
            default:      rgba = pack_rgba(raw[15:11], raw[10:5], raw[4:0], 2'b11);
        endcase
    end

endmodule

// File: rtl/texel_block_unpacker.sv
// Holds one 4x4 texel block and streams it out row-major as RGBA5652, TPC texels per beat.
// Optional TEXEL_UNPACK_PERF_EN adds perf_blocks / perf_stalls counters.
module texel_block_unpacker
    import texel_unpack_pkg::*;
#(
    parameter int TPC   = 2,
    parameter int IDX_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BLOCK_W-1:0]    in_block,
    input  logic [1:0]            in_fmt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RGBA_W*TPC-1:0] out_texels,
    output logic [IDX_W-1:0]      out_idx,
    output logic                  out_last,
    output logic                  fmt_err
`ifdef TEXEL_UNPACK_PERF_EN
    ,
    output logic [15:0]           perf_blocks,
    output logic [15:0]           perf_stalls
`endif
);

    localparam int               BEATS    = TEXELS_PER_BLOCK / TPC;
    localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(TPC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((BEATS - 1) * TPC);

    state_e               state_p1, state_nxt;
    logic [IDX_W-1:0]     idx_p1, idx_nxt;
    logic                 fmt_err_p1;
    logic [BLOCK_W-1:0]   blk_p1;
    fmt_e                 fmt_p1;

    logic accept;
    logic fire;
    logic last;

    assign out_valid = (state_p1 == ST_STREAM);
    assign last      = (idx_p1 == IDX_LAST);
    assign out_last  = out_valid && last;
    assign fire      = out_valid && out_ready;
    // The slot frees in the same cycle the final beat leaves, so blocks chain without a bubble.
    assign in_ready  = !out_valid || (fire && last);
    assign accept    = in_valid && in_ready;
    assign out_idx   = idx_p1;
    assign fmt_err   = fmt_err_p1;

    always_comb begin
        state_nxt = state_p1;
        idx_nxt   = idx_p1;
        if (accept) begin
            state_nxt = ST_STREAM;
            idx_nxt   = '0;
        end else if (fire) begin
            if (last) begin
                state_nxt = ST_IDLE;
                idx_nxt   = '0;
            end else begin
                idx_nxt = idx_p1 + IDX_STEP;
            end
        end
    end

    // ---- stage p1: control state ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p1   <= ST_IDLE;
            idx_p1     <= '0;
            fmt_err_p1 <= 1'b0;
        end else begin
            state_p1   <= state_nxt;
            idx_p1     <= idx_nxt;
            fmt_err_p1 <= accept && (fmt_e'(in_fmt) == FMT_RSVD);
        end
    end

    // ---- stage p1: held block, captured only on acceptance ----
    always_ff @(posedge clk) begin
        if (accept) begin
            blk_p1 <= in_block;
            fmt_p1 <= fmt_e'(in_fmt);
        end
    end

    for (genvar k = 0; k < TPC; k++) begin : g_lane
        logic [IDX_W-1:0]   tidx;
        logic [TEXEL_W-1:0] raw;

        assign tidx = idx_p1 + IDX_W'(k);

        // L8 packs twice as many texels per bit, so its byte lives at t*8, not t*16.
        always_comb begin
            if (fmt_p1 == FMT_L8) begin
                raw = {{(TEXEL_W - L8_W){1'b0}}, blk_p1[{1'b0, tidx, 3'b000} +: L8_W]};
            end else begin
                raw = blk_p1[{tidx, 4'b0000} +: TEXEL_W];
            end
        end

        texel_fmt_decode u_decode (
            .raw  (raw),
            .fmt  (fmt_p1),
            .rgba (out_texels[k*RGBA_W +: RGBA_W])
        );
    end

`ifdef TEXEL_UNPACK_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_blocks <= '0;
            perf_stalls <= '0;
        end else begin
            if (accept) begin
                perf_blocks <= perf_blocks + 16'd1;
            end
            if (out_valid && !out_ready) begin
                perf_stalls <= perf_stalls + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_texel_block_unpacker.sv
// Self-checking bench for texel_block_unpacker: decode table, hand sequences, random traffic vs a reference model.
module tb_texel_block_unpacker;
    import texel_unpack_pkg::*;

    localparam int TPC   = 2;
    localparam int BEATS = 16 / TPC;
    localparam int LW    = 18 * TPC;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [255:0]   in_block = '0;
    logic [1:0]     in_fmt = 2'd0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [LW-1:0]  out_texels;
    logic [3:0]     out_idx;
    logic           out_last;
    logic           fmt_err;
`ifdef TEXEL_UNPACK_PERF_EN
    logic [15:0]    perf_blocks;
    logic [15:0]    perf_stalls;
`endif

    texel_block_unpacker #(.TPC(TPC), .IDX_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_block   (in_block),
        .in_fmt     (in_fmt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_texels (out_texels),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .fmt_err    (fmt_err)
`ifdef TEXEL_UNPACK_PERF_EN
        ,
        .perf_blocks(perf_blocks),
        .perf_stalls(perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: decoded straight from the format definitions using integer arithmetic.
    function automatic logic [17:0] ref_texel(input logic [255:0] blk, input logic [1:0] fmt, input int t);
        int p, l, a, r, g, b, r5, g6, b5, a2;
        p = int'(blk[t*16 +: 16]);
        l = int'(blk[t*8 +: 8]);
        case (fmt)
            2'd1: begin
                a = (p / 4096) % 16; r = (p / 256) % 16; g = (p / 16) % 16; b = p % 16;
                r5 = r * 2 + r / 8; g6 = g * 4 + g / 4; b5 = b * 2 + b / 8; a2 = a / 4;
            end
            2'd2: begin
                r5 = l / 8; g6 = l / 4; b5 = l / 8; a2 = 3;
            end
            default: begin
                r5 = p / 2048; g6 = (p / 32) % 64; b5 = p % 32; a2 = 3;
            end
        endcase
        return 18'(r5 * 8192 + g6 * 128 + b5 * 4 + a2);
    endfunction

    typedef struct {
        logic [3:0]    idx;
        logic          last;
        logic [LW-1:0] tex;
    } beat_t;

    beat_t exp_q[$];
    bit    started = 0;
    bit    mon_ready;
    logic  exp_fmt_err = 1'b0;
    int    model_stalls = 0;

    function automatic void push_block(input logic [255:0] blk, input logic [1:0] fmt);
        beat_t bt;
        for (int b = 0; b < BEATS; b++) begin
            bt.idx  = 4'(b * TPC);
            bt.last = (b == BEATS - 1);
            for (int k = 0; k < TPC; k++) bt.tex[k*18 +: 18] = ref_texel(blk, fmt, b * TPC + k);
            exp_q.push_back(bt);
        end
    endfunction

    // Monitor: one block in flight at a time, so the queue holds the remaining beats of it.
    always @(negedge clk) begin
        mon_ready = (exp_q.size() == 0) || (out_ready && exp_q.size() == 1);
        if (started) begin
            check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            check("in_ready", 64'(in_ready), 64'(mon_ready));
            check("fmt_err", 64'(fmt_err), 64'(exp_fmt_err));
            if (exp_q.size() != 0 && out_valid) begin
                check("out_idx", 64'(out_idx), 64'(exp_q[0].idx));
                check("out_last", 64'(out_last), 64'(exp_q[0].last));
                check("out_texels", 64'(out_texels), 64'(exp_q[0].tex));
            end
        end
        if (rst) begin
            exp_q.delete();
            exp_fmt_err = 1'b0;
            model_stalls = 0;
            started = 1;
        end else if (started) begin
            exp_fmt_err = in_valid && mon_ready && (in_fmt == 2'd3);
            if (exp_q.size() != 0 && !out_ready) model_stalls++;
            if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
            if (in_valid && mon_ready) push_block(in_block, in_fmt);
        end
    end

    bit rand_ready = 0;
    bit ready_val  = 1;
    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
    end

    task automatic send_block(input logic [255:0] blk, input logic [1:0] fmt);
        int i;
        @(posedge clk); #2;
        in_valid = 1'b1; in_block = blk; in_fmt = fmt;
        for (i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (i == 300) begin
            n_vec++; n_miss++;
            $display("FAIL send_block: in_ready never seen, got timeout required acceptance");
        end
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !in_valid) break;
        end
        if (i == 1000) begin
            n_vec++; n_miss++;
            $display("FAIL wait_idle: got %0d beats pending required 0", exp_q.size());
        end
    endtask

    typedef struct packed {
        logic [1:0]  fmt;
        logic [15:0] raw;
        logic [17:0] exp;
    } vec_t;

    vec_t         vecs[10];
    logic [255:0] blk;

    initial begin
        vecs[0] = '{2'd0, 16'hF800, 18'h3E003};
        vecs[1] = '{2'd1, 16'hF8C4, 18'h239A3};
        vecs[2] = '{2'd1, 16'h4000, 18'h00001};
        vecs[3] = '{2'd2, 16'h00A5, 18'h294D3};
        vecs[4] = '{2'd3, 16'h1234, 18'h048D3};
        vecs[5] = '{2'd0, 16'h0000, 18'h00003};
        vecs[6] = '{2'd0, 16'hFFFF, 18'h3FFFF};
        vecs[7] = '{2'd1, 16'hFFFF, 18'h3FFFF};
        vecs[8] = '{2'd2, 16'h0000, 18'h00003};
        vecs[9] = '{2'd2, 16'h00FF, 18'h3FFFF};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_out_idx", 64'(out_idx), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Decode table: every texel of the block carries the same raw value.
        for (int i = 0; i < 10; i++) begin
            blk = (vecs[i].fmt == 2'd2) ? {32{vecs[i].raw[7:0]}} : {16{vecs[i].raw}};
            send_block(blk, vecs[i].fmt);
            @(negedge clk);
            check($sformatf("vec%0d_lane0", i), 64'(out_texels[17:0]), 64'(vecs[i].exp));
            check($sformatf("vec%0d_lane1", i), 64'(out_texels[35:18]), 64'(vecs[i].exp));
            wait_idle();
        end

        // RGB565 ramp, continuous consumption: indices 0,2,..,14 and a single last beat.
        for (int t = 0; t < 16; t++) blk[t*16 +: 16] = 16'hF800 + 16'(t);
        send_block(blk, 2'd0);
        for (int b = 0; b < BEATS; b++) begin
            @(negedge clk);
            check("ramp_idx", 64'(out_idx), 64'(b * TPC));
            check("ramp_last", 64'(out_last), 64'(b == BEATS - 1));
        end
        wait_idle();

        // L8 bytes 0x00..0x0F.
        blk = '0;
        for (int t = 0; t < 16; t++) blk[t*8 +: 8] = 8'(t);
        send_block(blk, 2'd2);
        wait_idle();

        // Back-to-back: second block taken on the first block's last beat, no gap.
        for (int t = 0; t < 8; t++) blk[t*32 +: 32] = $urandom;
        send_block(blk, 2'd0);
        fork
            begin
                logic [255:0] blk2;
                for (int t = 0; t < 8; t++) blk2[t*32 +: 32] = $urandom;
                send_block(blk2, 2'd1);
            end
            begin
                for (int i = 0; i < 2 * BEATS; i++) begin
                    @(negedge clk);
                    check("b2b_valid", 64'(out_valid), 64'd1);
                    check("b2b_idx", 64'(out_idx), 64'((i * TPC) % 16));
                end
            end
        join
        wait_idle();

        // Random traffic with random back-pressure.
        rand_ready = 1;
        for (int n = 0; n < 8; n++) begin
            for (int t = 0; t < 8; t++) blk[t*32 +: 32] = $urandom;
            send_block(blk, 2'($urandom_range(0, 3)));
        end
        wait_idle();
        rand_ready = 0;
        ready_val  = 1;
        repeat (2) @(negedge clk);

        // Reset at beat 3, then a reserved-format block.
        for (int t = 0; t < 8; t++) blk[t*32 +: 32] = $urandom;
        send_block(blk, 2'd0);
        begin
            int i;
            for (i = 0; i < 50; i++) begin
                @(negedge clk);
                if (out_idx == 4'd4) break;
            end
            if (i == 50) begin
                n_vec++; n_miss++;
                $display("FAIL reach_beat2: got timeout required out_idx 4");
            end
        end
        ready_val = 0;
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_ready", 64'(in_ready), 64'd1);
        check("rst_mid_idx", 64'(out_idx), 64'd0);
        check("rst_mid_last", 64'(out_last), 64'd0);
        ready_val = 1;
        send_block({16{16'h1234}}, 2'd3);
        @(negedge clk);
        check("rsvd_fmt_err_pulse", 64'(fmt_err), 64'd1);
        check("rsvd_lane0", 64'(out_texels[17:0]), 64'h048D3);
        @(negedge clk);
        check("rsvd_fmt_err_clear", 64'(fmt_err), 64'd0);
        check("rsvd_lane1", 64'(out_texels[35:18]), 64'h048D3);
        wait_idle();
`ifdef TEXEL_UNPACK_PERF_EN
        check("perf_blocks", 64'(perf_blocks), 64'd1);
        check("perf_stalls", 64'(perf_stalls), 64'(model_stalls));
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/texel_block_unpacker.md
Name: texel_block_unpacker

Overview:
- Sequential, parametrised successor to the single-texel RGB565 decoder.
- Accepts one 4x4 texel block (256-bit) per valid/ready handshake and stores it.
- Streams the 16 texels out in row-major order as RGBA5652 (18 bit), TPC texels per beat.
- Supports RGB565, ARGB4444 and L8 source formats. Sits between the texture cache fill path and the cache data RAM write port.

Parameters:
- TPC, 2, texels per output beat; legal values 1, 2, 4. BEATS = 16/TPC.
- IDX_W, 4, texel index width; fixed at 4, exposed for the package.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  block offered
- in_ready  out  1  block accepted when in_valid&&in_ready
- in_block  in  256  texels row-major; texel t occupies [t*16 +: 16] (L8 uses [t*8 +: 8])
- in_fmt  in  2  0=RGB565, 1=ARGB4444, 2=L8, 3=reserved
- out_valid  out  1  beat valid
- out_ready  in  1  beat consumed when out_valid&&out_ready
- out_texels  out  18*TPC  lane k = texel out_idx+k, {R5,G6,B5,A2}
- out_idx  out  4  index of lane 0 texel
- out_last  out  1  final beat of block
- fmt_err  out  1  one-cycle pulse on acceptance of in_fmt=3

Behaviour:
- States: IDLE (no block held), STREAM (block held, out_valid=1).
- Reset: state IDLE; out_valid=0, out_idx=0, out_last=0, fmt_err=0, beat counter 0; in_ready=1 during the first cycle after reset; in_block and fmt registers are don't-care.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). This is combinational, so a back-to-back block is accepted with no bubble.
- Acceptance in cycle N: block and fmt registered; beat=0; out_valid=1 from cycle N+1 (latency 1).
- Beat advances only on out_valid&&out_ready. out_idx = beat*TPC. out_last = (beat==BEATS-1).
- Final beat consumed:
  - With no new block: go to IDLE, out_valid=0 next cycle.
  - With a simultaneous new block: stay in STREAM, beat=0, new data is visible next cycle.
- out_texels are decoded combinationally from the held registers and stay stable while stalled (out_valid&&!out_ready).
- Decode rules:
  - RGB565: {p[15:11], p[10:5], p[4:0], 2'b11}.
  - ARGB4444 (p = A[15:12] R[11:8] G[7:4] B[3:0]): R5={R,R[3]}, G6={G,G[3:2]}, B5={B,B[3]}, A2=A[3:2].
  - L8: R5=l[7:3], G6=l[7:2], B5=l[7:3], A2=2'b11.
  - Reserved fmt: decoded as RGB565; fmt_err pulses in the cycle after acceptance.
- in_valid while in_ready=0 is ignored; the source must hold it.
- Reset mid-stream: the held block is discarded, outputs return to reset values next cycle, and no further beats are emitted.

Optional Feature:
- Macro TEXEL_UNPACK_PERF_EN.
- Defined: adds outputs perf_blocks[15:0] (blocks accepted) and perf_stalls[15:0] (cycles with out_valid&&!out_ready). Both wrap at 16 bits and are cleared by rst.
- Undefined: these ports and counters are absent; the remaining behaviour is identical.

Decomposition:
- Package texel_unpack_pkg holds:
  - the fmt enum (FMT_RGB565=0, FMT_ARGB4444=1, FMT_L8=2, FMT_RSVD=3);
  - RGBA5652 width constant 18;
  - BLOCK_W=256 and TEXELS_PER_BLOCK=16.
- One combinational sub-module texel_fmt_decode: 16-bit raw plus fmt in, 18-bit RGBA5652 out. It is instantiated TPC times, and the L8 byte is pre-selected by the parent.

Test Plan:
1. TPC=2, RGB565 block with texel t = 16'hF800+t, out_ready=1: 8 beats; out_idx 0,2,...,14; beat 0 lane0 = {5'h1F,6'h00,5'h00,2'b11}; out_last on beat 7 only.
2. ARGB4444 texel 16'hF8C4 -> R5=5'b10001, G6=6'b110011, B5=5'b01000, A2=2'b11. Texel 16'h4000 -> A2=2'b01.
3. L8 byte 8'hA5 -> {5'h14, 6'h29, 5'h14, 2'b11}. Block bytes are 8'h00..8'h0F, checked at each index.
4. Two blocks back-to-back with out_ready=1: second accepted in the same cycle as the first's last beat; 16 beats (TPC=2) with no gap; out_valid never drops.
5. out_ready toggled 0/1 randomly: out_texels and out_idx are held during stalls; in_ready=0 throughout STREAM except during the final-beat handshake.
6. Assert rst at beat 3: out_valid=0 next cycle; in_ready=1; a reserved-fmt block then yields a one-cycle fmt_err pulse and RGB565-decoded data. With TEXEL_UNPACK_PERF_EN, perf_blocks=1 after this sequence.
